fft_frame_ctrl: RTL

Frame sequencer for the streaming FFT core in the spectrum-analysis path. A falling edge on the start key arms one capture. The block then streams exactly `N_POINTS` ADC samples into the FFT slave port and collects the same number of output bins. It writes each bin's magnitude estimate (|re|+|im|) into the spectrum RAM and reports completion or framing errors to the measurement logic.

---
 rtl/fft_frame_ctrl_if.sv | 24 ++
 rtl/fft_frame_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl_if.sv
// Streaming link between the frame sequencer and the FFT core: input stream
// (s_*) toward the FFT and output stream (m_*) back from it.
interface fft_frame_ctrl_if #(
  parameter int DATA_W = 16
);
  logic [2*DATA_W-1:0] s_tdata;
  logic                s_tvalid;
  logic                s_tlast;
  logic                s_tready;
  logic [2*DATA_W-1:0] m_tdata;
  logic                m_tvalid;
  logic                m_tlast;
  logic                m_tready;

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the streaming FFT: key-armed capture of N_POINTS samples,
// |re|+|im| spectrum write-back. Define FFT_FRAME_CONT_EN for back-to-back frames.
//
// state  | meaning
// IDLE   | waiting for a start key press
// LOAD   | streaming ADC samples into the FFT
// UNLOAD | collecting bins and writing magnitudes to RAM
// DONE   | frame complete, pulse done
module fft_frame_ctrl #(
  parameter int N_POINTS = 1024,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key,
  input  logic signed [DATA_W-1:0] adc_data,
  input  logic                     adc_valid,
  fft_frame_ctrl_if.master         fft,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W:0]          ram_din,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE, LOAD, UNLOAD, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

  state_t                    state;
  logic                      key_d0;
  logic                      key_d1;
  logic                      start;
  logic [ADDR_W-1:0]         in_cnt;
  logic [ADDR_W-1:0]         out_cnt;
  logic signed [DATA_W-1:0]  re;
  logic signed [DATA_W-1:0]  im;
  logic [DATA_W-1:0]         abs_re;
  logic [DATA_W-1:0]         abs_im;
  logic [DATA_W:0]           mag;

  assign start = key_d1 & ~key_d0;

  // Negating the most negative value wraps to the same bit pattern, which read
  // unsigned is exactly 2^(DATA_W-1), so no saturation is needed.
  assign re     = fft.m_tdata[DATA_W-1:0];
  assign im     = fft.m_tdata[2*DATA_W-1:DATA_W];
  assign abs_re = re[DATA_W-1] ? DATA_W'(-re) : DATA_W'(re);
  assign abs_im = im[DATA_W-1] ? DATA_W'(-im) : DATA_W'(im);
  assign mag    = {1'b0, abs_re} + {1'b0, abs_im};

  assign fft.s_tvalid = (state == LOAD) && adc_valid;
  assign fft.s_tdata  = {{DATA_W{1'b0}}, adc_data};
  assign fft.s_tlast  = (state == LOAD) && (in_cnt == LAST_IDX);
  assign fft.m_tready = (state == UNLOAD);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      key_d0   <= 1'b1;
      key_d1   <= 1'b1;
      in_cnt   <= '0;
      out_cnt  <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      key_d0 <= key;
      key_d1 <= key_d0;
      ram_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            in_cnt  <= '0;
            out_cnt <= '0;
            err     <= 1'b0;
          end
        end
        LOAD: begin
          if (adc_valid) begin
            if (fft.s_tready) begin
              in_cnt <= in_cnt + 1'b1;
              if (in_cnt == LAST_IDX) state <= UNLOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        UNLOAD: begin
          if (fft.m_tvalid) begin
            ram_we   <= 1'b1;
            ram_addr <= out_cnt;
            ram_din  <= mag;
            out_cnt  <= out_cnt + 1'b1;
            // tlast early or missing is flagged; the frame length stays fixed
            if (fft.m_tlast != (out_cnt == LAST_IDX)) err <= 1'b1;
            if (out_cnt == LAST_IDX) state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b1;
`ifdef FFT_FRAME_CONT_EN
          state   <= LOAD;
          in_cnt  <= '0;
          out_cnt <= '0;
          err     <= 1'b0;
`else
          state   <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
